// File: rtl/vj_pkg.sv
// Definitions shared by the window statistics blocks: the controller state
// type and the default scan-window side length.
package vj_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SQRT,
        DONE
    } state_t;

    localparam int WINDOW_SIZE = 24;

endpackage

// File: rtl/isqrt_seq.sv
// Restoring integer square root, one result bit per cycle. The first digit is
// resolved on the start edge, so the root is final W cycles after start.
module isqrt_seq #(
    parameter int W = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [2*W-1:0] radicand,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   root
);

    localparam int CW = $clog2(W) + 1;

    logic [2*W-1:0] rad_q, src_rad, rad_n;
    logic [W+1:0]   rem_q, src_rem, rem_n, trial, test;
    logic [W-1:0]   root_q, src_root, root_n;
    logic [CW-1:0]  cnt_q;

    always_comb begin
        src_rad  = start ? radicand : rad_q;
        src_rem  = start ? '0 : rem_q;
        src_root = start ? '0 : root_q;
        // Remainder never exceeds 2*root, so its top two bits are always zero here.
        trial    = {src_rem[W-1:0], src_rad[2*W-1 -: 2]};
        test     = {src_root, 2'b01};
        rad_n    = src_rad << 2;
        if (trial >= test) begin
            rem_n  = trial - test;
            root_n = {src_root[W-2:0], 1'b1};
        end else begin
            rem_n  = trial;
            root_n = {src_root[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rad_q  <= rad_n;
                rem_q  <= rem_n;
                root_q <= root_n;
                cnt_q  <= CW'(1);
                busy   <= 1'b1;
            end else if (busy) begin
                rad_q  <= rad_n;
                rem_q  <= rem_n;
                root_q <= root_n;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign root = root_q;

endmodule

// File: rtl/window_std_dev_seq.sv
// Window standard deviation from integral-image corners: N*sum(x^2) - sum(x)^2,
// clamped at zero, then an iterative square root (or raw variance when OUT_VAR=1).
module window_std_dev_seq
    import vj_pkg::*;
#(
    parameter int WIN     = WINDOW_SIZE,
    parameter int W       = 32,
    parameter int OUT_VAR = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] tl,
    input  logic [W-1:0] tr,
    input  logic [W-1:0] bl,
    input  logic [W-1:0] br,
    input  logic [W-1:0] tl_sq,
    input  logic [W-1:0] tr_sq,
    input  logic [W-1:0] bl_sq,
    input  logic [W-1:0] br_sq,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] std_dev,
    output logic         neg,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int N  = WIN * WIN;
    localparam int VW = 2 * W + 2;

    state_t         state;
    logic [W-1:0]   c_tl, c_tr, c_bl, c_br;
    logic [W-1:0]   c_tl_sq, c_tr_sq, c_bl_sq, c_br_sq;
    logic           sat_q;

    logic [W-1:0]   sum, sqs;
    logic [VW-1:0]  prod_n, prod_s, v_raw, v_clamp;
    logic           v_neg, v_sat;
    logic           sq_start, sq_busy, sq_done;
    logic [W-1:0]   sq_root;

    // Both products are far below 2^(VW-1), so the unsigned difference is the
    // exact two's-complement value and its MSB is the sign.
    always_comb begin
        sum     = c_br - c_bl + c_tl - c_tr;
        sqs     = c_br_sq - c_bl_sq + c_tl_sq - c_tr_sq;
        prod_n  = VW'(N) * {{(W + 2){1'b0}}, sqs};
        prod_s  = {{(W + 2){1'b0}}, sum} * {{(W + 2){1'b0}}, sum};
        v_raw   = prod_n - prod_s;
        v_neg   = v_raw[VW-1];
        v_clamp = v_neg ? '0 : v_raw;
        v_sat   = |v_clamp[VW-1:2*W];
    end

    assign sq_start = (state == CALC) && (OUT_VAR == 0) && !sq_busy;

    isqrt_seq #(.W(W)) u_isqrt (
        .clock    (clock),
        .reset    (reset),
        .start    (sq_start),
        .radicand (v_clamp[2*W-1:0]),
        .busy     (sq_busy),
        .done     (sq_done),
        .root     (sq_root)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            std_dev   <= '0;
            neg       <= 1'b0;
            sat_q     <= 1'b0;
            c_tl      <= '0;
            c_tr      <= '0;
            c_bl      <= '0;
            c_br      <= '0;
            c_tl_sq   <= '0;
            c_tr_sq   <= '0;
            c_bl_sq   <= '0;
            c_br_sq   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_tl     <= tl;
                        c_tr     <= tr;
                        c_bl     <= bl;
                        c_br     <= br;
                        c_tl_sq  <= tl_sq;
                        c_tr_sq  <= tr_sq;
                        c_bl_sq  <= bl_sq;
                        c_br_sq  <= br_sq;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    neg   <= v_neg;
                    sat_q <= v_sat;
                    if (OUT_VAR != 0) begin
                        std_dev   <= v_clamp[W-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= SQRT;
                    end
                end
                SQRT: begin
                    if (sq_done) begin
                        std_dev   <= sat_q ? '1 : sq_root;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_std_dev_seq.sv
// Bench for window_std_dev_seq: table and random vectors through a scoreboard,
// plus stall, ignored-input, reset-mid-root and variance-output sequences.
module tb_window_std_dev_seq;

    localparam int W = 32;

    typedef struct {
        logic [31:0] tl, tr, bl, br, tl_sq, tr_sq, bl_sq, br_sq;
        logic [31:0] sd;
        logic        ng;
    } vec_t;

    typedef struct {
        logic [31:0] sd;
        logic        ng;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  tl = '0, tr = '0, bl = '0, br = '0;
    logic [W-1:0]  tl_sq = '0, tr_sq = '0, bl_sq = '0, br_sq = '0;
    logic          in_valid0 = 1'b0, out_ready0 = 1'b1;
    logic          in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic          in_ready0, out_valid0, neg0;
    logic          in_ready1, out_valid1, neg1;
    logic [W-1:0]  std0, std1;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[9];

    always #5 clock = ~clock;

    window_std_dev_seq #(.WIN(24), .W(W), .OUT_VAR(0)) dut0 (
        .clock(clock), .reset(reset),
        .tl(tl), .tr(tr), .bl(bl), .br(br),
        .tl_sq(tl_sq), .tr_sq(tr_sq), .bl_sq(bl_sq), .br_sq(br_sq),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .std_dev(std0), .neg(neg0), .out_valid(out_valid0), .out_ready(out_ready0)
    );

    window_std_dev_seq #(.WIN(24), .W(W), .OUT_VAR(1)) dut1 (
        .clock(clock), .reset(reset),
        .tl(tl), .tr(tr), .bl(bl), .br(br),
        .tl_sq(tl_sq), .tr_sq(tr_sq), .bl_sq(bl_sq), .br_sq(br_sq),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .std_dev(std1), .neg(neg1), .out_valid(out_valid1), .out_ready(out_ready1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a_tl, a_tr, a_bl, a_br,
                                input logic [31:0] s_tl, s_tr, s_bl, s_br,
                                input logic [31:0] sd, input logic ng);
        vec_t t;
        t.tl = a_tl; t.tr = a_tr; t.bl = a_bl; t.br = a_br;
        t.tl_sq = s_tl; t.tr_sq = s_tr; t.bl_sq = s_bl; t.br_sq = s_br;
        t.sd = sd; t.ng = ng;
        return t;
    endfunction

    // Reference: exact variance in 66 bits, root found by greedy bit search.
    function automatic exp_t model(input vec_t t);
        logic [31:0] s, q, r, c;
        logic [65:0] v;
        exp_t e;
        s = t.br - t.bl + t.tl - t.tr;
        q = t.br_sq - t.bl_sq + t.tl_sq - t.tr_sq;
        v = 66'(q) * 66'd576 - 66'(s) * 66'(s);
        e.ng = v[65];
        e.sd = '0;
        if (!v[65]) begin
            r = '0;
            for (int b = 31; b >= 0; b--) begin
                c = r | (32'd1 << b);
                if (66'(c) * 66'(c) <= v) r = c;
            end
            e.sd = r;
        end
        return e;
    endfunction

    task automatic set_corners(input vec_t t);
        tl = t.tl; tr = t.tr; bl = t.bl; br = t.br;
        tl_sq = t.tl_sq; tr_sq = t.tr_sq; bl_sq = t.bl_sq; br_sq = t.br_sq;
    endtask

    task automatic scramble();
        tl = $urandom; tr = $urandom; bl = $urandom; br = $urandom;
        tl_sq = $urandom; tr_sq = $urandom; bl_sq = $urandom; br_sq = $urandom;
    endtask

    // Present a vector to dut0 until accepted; corners are scrambled afterwards.
    task automatic send0(input vec_t t, input bit push);
        int w;
        exp_t e;
        @(posedge clock); #1;
        set_corners(t);
        in_valid0 = 1'b1;
        w = 0;
        while (!in_ready0 && w < 200) begin
            @(posedge clock); #1;
            w++;
        end
        if (w >= 200) check("accept_timeout", 64'(w), 64'd0);
        if (push) begin
            e.sd = t.sd; e.ng = t.ng;
            sb.push_back(e);
        end
        @(posedge clock); #1;
        in_valid0 = 1'b0;
        scramble();
    endtask

    // Count cycles (sampled mid-cycle) until out_valid is seen.
    task automatic wait_out0(input int exp_lat);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!out_valid0 && k < 200);
        check("latency0", 64'(k), 64'(exp_lat));
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid0 && out_ready0) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("std_dev0", 64'(std0), 64'(e.sd));
                check("neg0", 64'(neg0), 64'(e.ng));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        exp_t e;
        int   k;

        tbl[0] = mk(0, 0, 0, 2880, 0, 0, 0, 14400, 0, 1'b0);
        tbl[1] = mk(0, 0, 0, 2880, 0, 0, 0, 28800, 2880, 1'b0);
        tbl[2] = mk(0, 0, 0, 100, 0, 0, 0, 0, 0, 1'b1);
        tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        tbl[4] = mk(0, 0, 0, 1, 0, 0, 0, 1, 23, 1'b0);
        tbl[5] = mk(3, 3, 0, 0, 4, 0, 0, 0, 48, 1'b0);
        tbl[6] = mk(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 24, 1'b0);
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1572863, 1'b0);
        tbl[8] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1'b1);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready0", 64'(in_ready0), 64'd1);
        check("rst_out_valid0", 64'(out_valid0), 64'd0);
        check("rst_std0", 64'(std0), 64'd0);
        check("rst_neg0", 64'(neg0), 64'd0);
        check("rst_in_ready1", 64'(in_ready1), 64'd1);
        check("rst_out_valid1", 64'(out_valid1), 64'd0);

        for (int i = 0; i < 9; i++) begin
            send0(tbl[i], 1'b1);
            wait_out0(W + 2);
        end

        for (int i = 0; i < 6; i++) begin
            t = mk($urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, 0, 1'b0);
            if (i < 3) begin
                t.tr = t.tl; t.bl = 0; t.br = $urandom_range(4000, 0);
            end
            e = model(t);
            t.sd = e.sd; t.ng = e.ng;
            send0(t, 1'b1);
            wait_out0(W + 2);
        end

        // in_valid and corners change while busy; result must be unaffected
        send0(tbl[1], 1'b1);
        in_valid0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            scramble();
            @(posedge clock); #1;
        end
        check("busy_in_ready0", 64'(in_ready0), 64'd0);
        in_valid0 = 1'b0;
        wait_out0(W - 8);

        // downstream stall
        out_ready0 = 1'b0;
        send0(tbl[1], 1'b1);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!out_valid0 && k < 200);
        check("stall_latency", 64'(k), 64'(W + 2));
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stall_std", 64'(std0), 64'd2880);
            check("stall_neg", 64'(neg0), 64'd0);
            check("stall_in_ready", 64'(in_ready0), 64'd0);
            check("stall_out_valid", 64'(out_valid0), 64'd1);
        end
        @(posedge clock); #1;
        out_ready0 = 1'b1;
        @(posedge clock); #1;
        check("release_in_ready", 64'(in_ready0), 64'd1);
        check("release_out_valid", 64'(out_valid0), 64'd0);

        // reset during the fifth root cycle discards the transaction
        send0(tbl[7], 1'b0);
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midrst_in_ready", 64'(in_ready0), 64'd1);
        check("midrst_out_valid", 64'(out_valid0), 64'd0);
        check("midrst_std", 64'(std0), 64'd0);
        send0(tbl[4], 1'b1);
        wait_out0(W + 2);

        // variance output variant
        for (int i = 0; i < 2; i++) begin
            t = (i == 0) ? tbl[1] : tbl[2];
            @(posedge clock); #1;
            set_corners(t);
            in_valid1 = 1'b1;
            k = 0;
            while (!in_ready1 && k < 200) begin
                @(posedge clock); #1;
                k++;
            end
            @(posedge clock); #1;
            in_valid1 = 1'b0;
            scramble();
            k = 0;
            do begin
                @(negedge clock);
                k++;
            end while (!out_valid1 && k < 200);
            check("latency1", 64'(k), 64'd2);
            check("var_std1", 64'(std1), (i == 0) ? 64'd8294400 : 64'd0);
            check("var_neg1", 64'(neg1), (i == 0) ? 64'd0 : 64'd1);
            @(posedge clock); #1;
        end

        repeat (2) @(posedge clock);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/window_std_dev_seq.md
WINDOW_STD_DEV_SEQ -- requirements
Module: window_std_dev_seq

Interface
REQ-001 SHALL have parameter WIN, default 24: scan-window side length in pixels; pixel count N = WIN*WIN.
REQ-002 SHALL have parameter W, default 32: width of integral-image entries and of the result.
REQ-003 SHALL have parameter OUT_VAR, default 0: 0 = output standard deviation, 1 = output scaled variance.
REQ-004 SHALL have port clock, input, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports tl, tr, bl, br, each input, W: integral-image corner samples.
REQ-007 SHALL have ports tl_sq, tr_sq, bl_sq, br_sq, each input, W: squared-integral corner samples.
REQ-008 SHALL have port in_valid, input, 1: corner samples valid.
REQ-009 SHALL have port in_ready, output, 1: block can accept a sample set.
REQ-010 SHALL have port std_dev, output, W: result (low W bits of the variance when OUT_VAR=1).
REQ-011 SHALL have port neg, output, 1: scaled variance was negative and was clamped to 0.
REQ-012 SHALL have port out_valid, output, 1: std_dev and neg valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, SQRT, DONE, with one transaction in flight at a time.
REQ-015 SHALL assert in_ready only in IDLE; accept on in_valid && in_ready, registering all 8 corners, then go to CALC.
REQ-016 In CALC (1 cycle), SHALL form sum = br - bl + tl - tr and sqs = br_sq - bl_sq + tl_sq - tr_sq, both modulo 2^W, unsigned.
REQ-017 In CALC, SHALL form v = N*sqs - sum*sum as a signed 2W+2-bit value, with no truncation before the subtraction.
REQ-018 If v < 0, SHALL set v = 0 and neg = 1; otherwise neg = 0.
REQ-019 SHALL leave CALC for SQRT when OUT_VAR=0, and for DONE with std_dev = v[W-1:0] when OUT_VAR=1.
REQ-020 In SQRT, SHALL compute floor(sqrt(v[2W-1:0])) by restoring, digit-by-digit iteration, one result bit per cycle.
REQ-021 SHALL spend exactly W cycles in SQRT and then go to DONE.
REQ-022 SHALL saturate std_dev to 2^W-1 when v >= 2^(2W).
REQ-023 SHALL assert out_valid only in DONE; leave DONE for IDLE on out_valid && out_ready.
REQ-024 SHALL hold std_dev and neg stable while out_valid && !out_ready.
REQ-025 Latency: out_valid SHALL first be seen W+2 cycles after the accepting edge when OUT_VAR=0, and 2 cycles after it when OUT_VAR=1.
REQ-026 Back-to-back throughput: a new acceptance SHALL occur no earlier than the cycle after the DONE handshake.
REQ-027 SHALL ignore in_valid outside IDLE; input corners outside IDLE SHALL NOT affect the result.

Reset
REQ-028 Reset SHALL override all other inputs, including mid-CALC or mid-SQRT, discarding any in-flight transaction.
REQ-029 On reset, SHALL set state = IDLE, in_ready = 1, out_valid = 0, std_dev = 0, neg = 0, and clear all sqrt working registers.

Structure
REQ-030 Shared package vj_pkg SHALL hold the state enum typedef (IDLE/CALC/SQRT/DONE) and the default WINDOW_SIZE constant (24); WIN SHALL default from it.
REQ-031 The iterative root SHALL be one sub-module, isqrt_seq, parameterised by W.
  - isqrt_seq inputs: start, radicand (2W).
  - isqrt_seq outputs: busy, done pulse, root (W).

Verification
REQ-032 Scenario: WIN=24, W=32, OUT_VAR=0; tl=tr=bl=0, br=2880, all sq corners 0 except br_sq=14400 -> std_dev=0, neg=0, out_valid 34 cycles after acceptance.
REQ-033 Scenario: same config, br=2880, br_sq=28800, others 0 -> v=8294400, std_dev=2880, neg=0.
REQ-034 Scenario: br=100, all sq corners 0 -> v<0, std_dev=0, neg=1.
REQ-035 Scenario: out_ready held low 10 cycles after out_valid -> std_dev and neg stable, in_ready=0 throughout; handshake on release, in_ready=1 next cycle.
REQ-036 Scenario: reset asserted during the 5th SQRT cycle -> next cycle in_ready=1, out_valid=0, std_dev=0; a following transaction completes correctly.
REQ-037 Scenario: OUT_VAR=1 with REQ-033 inputs -> std_dev=8294400 exactly 2 cycles after acceptance.
